// File: rtl/mem_responder.sv
// mem_responder
// ---------------------------------------------------------------------------
// Word-addressed memory responder for the multicycle MIPS datapath. It takes
// one load/store/fetch request at a time and returns a single-cycle response
// a fixed LATENCY cycles after the request was accepted. Misaligned and
// out-of-range accesses are flagged and leave memory untouched.
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
// req_ready=1. req_ready is high only while idle and out of reset. Request
// inputs are sampled on that edge only; later changes are ignored. There is
// no response backpressure: resp_valid is high for exactly one cycle per
// accepted request and the consumer must take it in that cycle.
//
// Parameters:
//   DATA_W   data word width (32; byte enables assume 4 bytes)
//   DEPTH    number of words stored, power of two, 4..4096
//   LATENCY  cycles from acceptance to response, 1..15
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   req_valid   request present
//   req_ready   responder can accept a request this cycle
//   req_write   1 = store, 0 = load/fetch
//   req_addr    byte address
//   req_wdata   store data
//   req_be      store byte enables, bit i covers bits [8i+7:8i]
//   resp_valid  one-cycle response strobe
//   resp_rdata  load data; 0 for stores and errored accesses
//   resp_err    misaligned or out-of-range access, qualified by resp_valid
//   dbg_state   current FSM state (0 idle, 1 wait, 2 resp)
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_be,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [1:0]        dbg_state
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        cnt;

    // Request captured on the accepting edge.
    logic              wr_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        be_q;

    // Storage is deliberately not reset; contents are undefined until written.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     idx;
    logic              addr_err;
    logic              commit;

    assign idx      = addr_q[AW+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
    // The access happens on the edge that leaves WAIT.
    assign commit   = (state == S_WAIT) && (cnt == 4'd0);

    // Gated with rst so ready reads low while reset is held, not just after.
    assign req_ready = rst && (state == S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        cnt     <= CNT_INIT;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= addr_err;
                        // Stores and errored accesses report zero data.
                        if (addr_err || wr_q) begin
                            resp_rdata <= '0;
                        end else begin
                            resp_rdata <= mem[idx];
                        end
                    end
                end
                S_RESP: begin
                    resp_valid <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    // Byte-masked store. A reset during WAIT forces state to IDLE at once,
    // so commit cannot be true on the following edge and the store is lost.
    always_ff @(posedge clk) begin
        if (commit && wr_q && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;          // 0 drives the LATENCY=2 instance, 1 the LATENCY=1 one
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        ready0, rv0, err0, ready1, rv1, err1;
    logic [31:0] rd0, rd1;
    logic [1:0]  st0, st1;

    mem_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel), .req_ready(ready0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0), .dbg_state(st0)
    );

    mem_responder #(.DATA_W(32), .DEPTH(16), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel), .req_ready(ready1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1), .dbg_state(st1)
    );

    logic        ready, resp_valid, resp_err;
    logic [31:0] rdata;
    assign ready      = sel ? ready1 : ready0;
    assign resp_valid = sel ? rv1    : rv0;
    assign resp_err   = sel ? err1   : err0;
    assign rdata      = sel ? rd1    : rd0;

    // ---------------- reference model ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model [2][256];
    bit          known [2][256];
    logic [31:0] exp_q [$];

    function automatic int depth_of(input logic s);
        return s ? 16 : 256;
    endfunction

    function automatic int lat_of(input logic s);
        return s ? 1 : 2;
    endfunction

    function automatic logic is_err(input logic s, input logic [31:0] a);
        logic [31:0] lim;
        lim = 32'(depth_of(s) * 4);
        return (a[1:0] != 2'b00) || (a >= lim);
    endfunction

    task automatic model_store(input logic s, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] be);
        int i;
        i = int'(a >> 2);
        for (int b = 0; b < 4; b++)
            if (be[b]) model[s][i][8*b +: 8] = wd[8*b +: 8];
        if (be == 4'hF) known[s][i] = 1'b1;
    endtask

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic accept_only(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] be);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_be = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        // Scramble inputs: they must be ignored after acceptance.
        req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    endtask

    // Full transaction: called between edges with the selected DUT idle.
    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
        logic        exp_e;
        logic [31:0] exp_d;
        bit          chk_d;
        bit          got;
        int          lat;
        exp_e = is_err(sel, a);
        exp_d = 32'h0;
        chk_d = 1'b1;
        if (!exp_e && !wr) begin
            if (known[sel][int'(a >> 2)]) exp_d = model[sel][int'(a >> 2)];
            else chk_d = 1'b0;
        end
        check("ready_idle", ready, 1);
        accept_only(wr, a, wd, be);
        check("ready_busy", ready, 0);
        got = 1'b0;
        lat = 0;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (resp_valid) got = 1'b1;
            else check("ready_wait", ready, 0);
        end
        check("resp_seen", got, 1);
        check("latency", lat, lat_of(sel));
        check("ready_resp", ready, 0);
        check("resp_err", resp_err, exp_e);
        if (chk_d) check("resp_rdata", rdata, exp_d);
        if (wr && !exp_e) model_store(sel, a, wd, be);
        @(posedge clk);
        #1;
        check("resp_one_cycle", resp_valid, 0);
        check("ready_back", ready, 1);
        @(negedge clk);
    endtask

    task automatic rand_op(input int words);
        int          kind;
        logic [31:0] a;
        kind = $urandom_range(0, 9);
        if (kind < 7)       a = 32'($urandom_range(0, words - 1)) << 2;
        else if (kind == 7) a = (32'($urandom_range(0, words - 1)) << 2) | 32'($urandom_range(1, 3));
        else if (kind == 8) a = 32'(words * 4) + (32'($urandom_range(0, 63)) << 2);
        else                a = $urandom | 32'h8000_0000;
        do_req(1'($urandom), a, $urandom, 4'($urandom));
    endtask

    // ---------------- stimulus ----------------
    int          accepts, resps, low_run;
    logic        r, v;
    bit          got;
    int          waited;

    initial begin
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_ready_low", ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", resp_err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_after_rst", ready, 1);

        // Basic store / load
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        check("basic_readback", model[0][4], 32'hDEAD_BEEF);

        // Byte enables
        do_req(1'b1, 32'h10, 32'h1122_3344, 4'b0101);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);

        // Errors
        do_req(1'b1, 32'h0, 32'h0BAD_F00D, 4'hF);
        do_req(1'b0, 32'h13, 32'h0, 4'h0);
        do_req(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF);
        do_req(1'b0, 32'h0, 32'h0, 4'h0);

        // Reset during WAIT drops the store
        do_req(1'b1, 32'h20, 32'h0, 4'hF);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);          // leaves nonzero rdata held
        accept_only(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready", ready, 0);
        check("midrst_valid", resp_valid, 0);
        check("midrst_rdata", rdata, 0);
        check("midrst_err", resp_err, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready_back", ready, 1);
        @(negedge clk);
        do_req(1'b0, 32'h20, 32'h0, 4'h0);

        // Reset during RESP: store already committed
        accept_only(1'b1, 32'h24, 32'h55AA_1234, 4'hF);
        got = 1'b0;
        waited = 0;
        while (!got && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
            if (resp_valid) got = 1'b1;
        end
        check("resprst_seen", got, 1);
        rst = 1'b0;
        #1;
        check("resprst_valid", resp_valid, 0);
        model_store(1'b0, 32'h24, 32'h55AA_1234, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_req(1'b0, 32'h24, 32'h0, 4'h0);

        // Randomized mix
        for (int i = 0; i < 8; i++) do_req(1'b1, 32'(i) << 2, $urandom, 4'hF);
        for (int i = 0; i < 40; i++) rand_op(32);

        // Continuous req_valid with changing addresses
        accepts = 0; resps = 0; low_run = 0;
        exp_q.delete();
        req_write = 1'b0; req_wdata = $urandom; req_be = 4'($urandom);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            r = ready;
            v = resp_valid;
            if (v) begin
                resps++;
                if (exp_q.size() == 0) check("hs_extra_resp", 1, 0);
                else check("hs_rdata", rdata, exp_q.pop_front());
            end
            req_addr  = 32'($urandom_range(0, 7)) << 2;
            req_valid = 1'b1;
            if (r) begin
                if (accepts > 0) check("hs_ready_low", low_run, lat_of(1'b0) + 1);
                low_run = 0;
                accepts++;
                exp_q.push_back(model[0][int'(req_addr >> 2)]);
            end else begin
                low_run++;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                resps++;
                if (exp_q.size() == 0) check("hs_extra_resp", 1, 0);
                else check("hs_rdata", rdata, exp_q.pop_front());
            end
        end
        check("hs_resp_count", resps, accepts);
        check("hs_queue_empty", exp_q.size(), 0);

        // LATENCY=1, DEPTH=16 instance
        sel = 1'b1;
        @(negedge clk);
        do_req(1'b1, 32'h4, 32'hA5A5_0F0F, 4'hF);
        do_req(1'b0, 32'h4, 32'h0, 4'h0);
        do_req(1'b0, 32'h40, 32'h0, 4'h0);
        for (int i = 0; i < 16; i++) do_req(1'b1, 32'(i) << 2, $urandom, 4'hF);
        for (int i = 0; i < 30; i++) rand_op(16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
